// File: rtl/bp_pkg.sv
// Shared types for the jump-prediction resolve path: queue entry and resolver state.
package bp_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  hit;
        addr_t pred_pc;
    } jq_entry_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } jr_state_t;

endpackage

// File: rtl/jht_resolver_if.sv
// Decode/EXE/JHT/redirect-facing signal bundle of the jump resolver.
interface jht_resolver_if #(
    parameter int CNT_BITS = 16
);
    import bp_pkg::*;

    logic                push_valid;
    logic                push_ready;
    addr_t               push_pc;
    logic                push_hit;
    addr_t               push_pred_pc;
    logic                resolve_valid;
    addr_t               resolve_pc;
    addr_t               resolve_dest;
    logic                flush;
    logic                mispredict;
    addr_t               redirect_pc;
    logic                jht_is_write;
    addr_t               jht_exec_pc;
    addr_t               jht_dest_pc;
    logic                desync;
    logic [CNT_BITS-1:0] hit_cnt;
    logic [CNT_BITS-1:0] miss_cnt;

    modport slave (
        input  push_valid, push_pc, push_hit, push_pred_pc,
        input  resolve_valid, resolve_pc, resolve_dest, flush,
        output push_ready, mispredict, redirect_pc,
        output jht_is_write, jht_exec_pc, jht_dest_pc,
        output desync, hit_cnt, miss_cnt
    );

    modport master (
        output push_valid, push_pc, push_hit, push_pred_pc,
        output resolve_valid, resolve_pc, resolve_dest, flush,
        input  push_ready, mispredict, redirect_pc,
        input  jht_is_write, jht_exec_pc, jht_dest_pc,
        input  desync, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/jq_fifo.sv
// In-order queue of fetch-time jump predictions; wrap-bit pointers, clear beats push.
module jq_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  jq_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output jq_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    jq_entry_t   mem [DEPTH];
    logic        do_push, do_pop;

    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty   = wr_ptr == rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/jht_resolver.sv
// Checks fetch-time JHT predictions against EXE-resolved targets, redirects and updates the JHT.
module jht_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CNT_BITS = 16
) (
    input logic           clk,
    input logic           resetn,
    jht_resolver_if.slave bus
);
    jr_state_t state_q, state_d;
    jq_entry_t head, push_ent;
    logic      full, empty;
    logic      fifo_push, fifo_pop, fifo_clear;
    logic      rslv, head_match, correct, bad;

    assign push_ent = '{pc: bus.push_pc, hit: bus.push_hit, pred_pc: bus.push_pred_pc};

    jq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (push_ent),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Wrong-path resolves arriving during RECOVER are dropped.
    always_comb begin
        rslv       = bus.resolve_valid && (state_q == NORMAL);
        head_match = !empty && (head.pc == bus.resolve_pc);
        correct    = head_match && head.hit && (head.pred_pc == bus.resolve_dest);
        bad        = rslv && !correct;
    end

    assign bus.push_ready = !full && (state_q == NORMAL);
    assign fifo_push      = bus.push_valid && bus.push_ready && !bus.flush;
    assign fifo_pop       = rslv && correct;
    assign fifo_clear     = bus.flush || bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= NORMAL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (bad) state_d = RECOVER;
            RECOVER: state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
        if (bus.flush) state_d = NORMAL;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mispredict   <= 1'b0;
            bus.redirect_pc  <= '0;
            bus.jht_is_write <= 1'b0;
            bus.jht_exec_pc  <= '0;
            bus.jht_dest_pc  <= '0;
            bus.desync       <= 1'b0;
            bus.hit_cnt      <= '0;
            bus.miss_cnt     <= '0;
        end else begin
            bus.mispredict   <= bad;
            bus.jht_is_write <= bad;
            if (bad) begin
                bus.redirect_pc <= bus.resolve_dest;
                bus.jht_exec_pc <= bus.resolve_pc;
                bus.jht_dest_pc <= bus.resolve_dest;
                if (bus.miss_cnt != '1) bus.miss_cnt <= bus.miss_cnt + 1'b1;
            end
            if (rslv && correct && bus.hit_cnt != '1) bus.hit_cnt <= bus.hit_cnt + 1'b1;
            if (rslv && !head_match) bus.desync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jht_resolver.sv
// Randomized + directed bench for jht_resolver against a queue-based behavioural model.
module tb_jht_resolver;
    import bp_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT   = 4;
    localparam int CMAX  = (1 << CNT) - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    jht_resolver_if #(.CNT_BITS(CNT)) bus ();

    jht_resolver #(.DEPTH(DEPTH), .CNT_BITS(CNT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    jq_entry_t   mq[$];
    bit          m_rec, m_mp, m_wr, m_des;
    logic [31:0] m_rpc, m_epc, m_dpc;
    int          m_hit, m_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rec = 0; m_mp = 0; m_wr = 0; m_des = 0;
        m_rpc = '0; m_epc = '0; m_dpc = '0;
        m_hit = 0; m_miss = 0;
    endtask

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && !m_rec;
    endfunction

    task automatic check_outs();
        chk("mispredict",  32'(bus.mispredict),   32'(m_mp));
        chk("jht_is_write", 32'(bus.jht_is_write), 32'(m_wr));
        chk("redirect_pc", bus.redirect_pc,        m_rpc);
        chk("jht_exec_pc", bus.jht_exec_pc,        m_epc);
        chk("jht_dest_pc", bus.jht_dest_pc,        m_dpc);
        chk("desync",      32'(bus.desync),        32'(m_des));
        chk("hit_cnt",     32'(bus.hit_cnt),       32'(m_hit));
        chk("miss_cnt",    32'(bus.miss_cnt),      32'(m_miss));
    endtask

    task automatic drive_idle();
        bus.push_valid = 0; bus.push_pc = '0; bus.push_hit = 0; bus.push_pred_pc = '0;
        bus.resolve_valid = 0; bus.resolve_pc = '0; bus.resolve_dest = '0; bus.flush = 0;
    endtask

    // One clock: check ready, drive, advance model, check registered outputs at the next negedge.
    task automatic cycle(input bit pv, input addr_t ppc, input bit ph, input addr_t ppred,
                         input bit rv, input addr_t rpc, input addr_t rdest, input bit fl);
        bit rdy, bad, nrec;
        rdy = m_ready();
        chk("push_ready", 32'(bus.push_ready), 32'(rdy));
        bus.push_valid = pv; bus.push_pc = ppc; bus.push_hit = ph; bus.push_pred_pc = ppred;
        bus.resolve_valid = rv; bus.resolve_pc = rpc; bus.resolve_dest = rdest; bus.flush = fl;
        m_mp = 0; m_wr = 0; bad = 0; nrec = 0;
        if (!m_rec && rv) begin
            if (mq.size() > 0 && mq[0].pc == rpc) begin
                if (mq[0].hit && mq[0].pred_pc == rdest) begin
                    if (m_hit < CMAX) m_hit++;
                    void'(mq.pop_front());
                end else bad = 1;
            end else begin
                bad = 1;
                m_des = 1;
            end
            if (bad) begin
                if (m_miss < CMAX) m_miss++;
                m_mp = 1; m_wr = 1; m_rpc = rdest; m_epc = rpc; m_dpc = rdest; nrec = 1;
            end
        end
        if (fl || bad) mq.delete();
        else if (pv && rdy) mq.push_back('{pc: ppc, hit: ph, pred_pc: ppred});
        if (fl) nrec = 0;
        m_rec = nrec;
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, '0, '0, 0);
    endtask

    task automatic rand_cycle();
        bit pv, ph, rv, fl;
        addr_t ppc, ppred, rpc, rdest;
        pv    = $urandom_range(0, 9) < 6;
        ppc   = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        ph    = $urandom_range(0, 3) != 0;
        ppred = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
        rv    = $urandom_range(0, 9) < 4;
        rpc   = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        rdest = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
        if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
            rpc = mq[0].pc;
            if ($urandom_range(0, 9) < 7) rdest = mq[0].pred_pc;
        end
        fl = $urandom_range(0, 49) == 0;
        cycle(pv, ppc, ph, ppred, rv, rpc, rdest, fl);
    endtask

    initial begin
        drive_idle();
        model_reset();
        resetn = 0;
        repeat (2) @(negedge clk);
        check_outs();
        resetn = 1;

        // correct prediction
        cycle(1, 32'h1000, 1, 32'h2000, 0, '0, '0, 0);
        cycle(0, '0, 0, '0, 1, 32'h1000, 32'h2000, 0);
        chk("s1_hit_cnt", 32'(bus.hit_cnt), 32'd1);
        chk("s1_no_misp", 32'(bus.mispredict), 32'd0);

        // mispredict on a JHT miss
        cycle(1, 32'h1000, 0, 32'h0, 0, '0, '0, 0);
        cycle(0, '0, 0, '0, 1, 32'h1000, 32'h3000, 0);
        chk("s2_misp", 32'(bus.mispredict), 32'd1);
        chk("s2_redirect", bus.redirect_pc, 32'h3000);
        chk("s2_exec", bus.jht_exec_pc, 32'h1000);
        chk("s2_dest", bus.jht_dest_pc, 32'h3000);
        chk("s2_ready_recover", 32'(bus.push_ready), 32'd0);
        idle(1);
        chk("s2_misp_pulse", 32'(bus.mispredict), 32'd0);

        // mispredict on oldest of three drops younger; resolve in RECOVER ignored
        for (int i = 0; i < 3; i++) cycle(1, 32'h1100 + 32'(i) * 4, 0, '0, 0, '0, '0, 0);
        cycle(0, '0, 0, '0, 1, 32'h1100, 32'h5555, 0);
        cycle(0, '0, 0, '0, 1, 32'h1104, 32'h6666, 0);
        chk("s3_recover_ignored", bus.redirect_pc, 32'h5555);
        idle(1);

        // fill to DEPTH, then push+resolve on full queue
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'h2000 + 32'(i) * 4, 1, 32'h3000 + 32'(i) * 4, 0, '0, '0, 0);
        chk("s4_full_ready", 32'(bus.push_ready), 32'd0);
        cycle(1, 32'h2100, 1, 32'h0, 1, 32'h2000, 32'h3000, 0);
        chk("s4_ready_after_pop", 32'(bus.push_ready), 32'd1);
        cycle(1, 32'h2200, 1, 32'h0, 0, '0, '0, 0);
        chk("s4_full_again", 32'(bus.push_ready), 32'd0);

        // flush with concurrent push: queue empty, push dropped
        cycle(1, 32'h7000, 1, 32'h7100, 0, '0, '0, 1);
        cycle(0, '0, 0, '0, 1, 32'h7000, 32'h7100, 0);
        chk("s6_flush_desync", 32'(bus.desync), 32'd1);
        idle(1);

        // resolve against mismatching head
        cycle(1, 32'h1000, 1, 32'h2000, 0, '0, '0, 0);
        cycle(0, '0, 0, '0, 1, 32'h5000, 32'h6000, 0);
        chk("s5_redirect", bus.redirect_pc, 32'h6000);
        idle(1);
        chk("s5_empty_ready", 32'(bus.push_ready), 32'd1);

        for (int i = 0; i < 3000; i++) rand_cycle();

        // asynchronous reset mid-run
        #2 resetn = 0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        drive_idle();
        resetn = 1;
        idle(1);

        for (int i = 0; i < 1000; i++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
